// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS MEM stage: load/store size flags, writeback select,
// FSM states, MEM/WB and issue-context records, and access-size helpers.
package mips_mem_pkg;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  localparam logic [1:0] ST_SW = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SB = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  mtr;
    logic        rw;
  } memwb_t;

  // Everything the capture edge needs, frozen at issue.
  typedef struct packed {
    logic [1:0]  off;
    logic [2:0]  ldf;
    logic        store;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  mtr;
    logic        rw;
  } ctx_t;

  function automatic logic [1:0] acc_size(input logic store, input logic [2:0] ldf,
                                          input logic [1:0] stf);
    logic [1:0] sz;
    sz = SZ_WORD;
    if (store) begin
      case (stf)
        ST_SH:   sz = SZ_HALF;
        ST_SB:   sz = SZ_BYTE;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (ldf)
        LD_LH, LD_LHU: sz = SZ_HALF;
        LD_LB, LD_LBU: sz = SZ_BYTE;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned(input logic store, input logic [2:0] ldf,
                                      input logic [1:0] stf, input logic [1:0] off);
    logic bad;
    case (acc_size(store, ldf, stf))
      SZ_WORD: bad = (off != 2'b00);
      SZ_HALF: bad = off[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / data replication on the issue side,
// load lane extraction with sign/zero extension on the capture side.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  ld_flag_i,
  input  logic [1:0]  st_flag_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  cap_ld_flag_i,
  input  logic [1:0]  cap_offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (acc_size(is_store_i, ld_flag_i, st_flag_i))
      SZ_HALF: begin
        be_o    = 4'b0011 << offset_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    half     = cap_offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    byte_sel = rdata_i[8*cap_offset_i +: 8];
    case (cap_ld_flag_i)
      LD_LH:   rdata_o = {{16{half[15]}}, half};
      LD_LHU:  rdata_o = {16'h0, half};
      LD_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  rdata_o = {24'h0, byte_sel};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MIPS MEM stage: req/ack data-memory FSM, MEM/WB latch and upstream stall.
// Optional bus-timeout abort is compiled in with MEM_TIMEOUT_EN.
module stage_mem
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 16,
  parameter logic [31:0] RESET_PC_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic        inRegWrite,
  input  logic [1:0]  inMemtoReg,
  input  logic [31:0] inAlu,
  input  logic [31:0] inDataRt,
  input  logic [4:0]  inMuxRtRd,
  input  logic [2:0]  inflagLoadWordDividerMEM,
  input  logic [1:0]  inflagStoreWordDividerMEM,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        outStall,
  output logic        outAddrErr,
  output logic [31:0] outReadData,
  output logic [31:0] outAluWb,
  output logic [4:0]  outMuxRtRdWb,
  output logic [1:0]  outMemtoRegWb,
  output logic        outRegWriteWb
);

  if (TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be at least 2");
  end

  logic [0:0]  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  memwb_t      wb_q, wb_d;
  ctx_t        ctx_q, ctx_d;

  logic        mem_op, mis, go, timeout_hit;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  assign mem_op = inMemRead | inMemWrite;
  // A read+write request is a store, so inMemWrite alone picks the access size.
  assign mis    = mem_op & misaligned(inMemWrite, inflagLoadWordDividerMEM,
                                      inflagStoreWordDividerMEM, inAlu[1:0]);
  assign go     = (state_q == ST_IDLE) & mem_op & ~mis;

  mem_lane_align u_lane (
    .is_store_i    (inMemWrite),
    .ld_flag_i     (inflagLoadWordDividerMEM),
    .st_flag_i     (inflagStoreWordDividerMEM),
    .offset_i      (inAlu[1:0]),
    .wdata_i       (inDataRt),
    .be_o          (lane_be),
    .wdata_o       (lane_wdata),
    .cap_ld_flag_i (ctx_q.ldf),
    .cap_offset_i  (ctx_q.off),
    .rdata_i       (memRdata),
    .rdata_o       (lane_rdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == ST_BUSY) & ~memAck & (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (go) begin
      cnt_d = '0;
    end else if (state_q == ST_BUSY && !memAck && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    wb_d    = wb_q;
    ctx_d   = ctx_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d   = ST_BUSY;
          req_d     = 1'b1;
          we_d      = inMemWrite;
          addr_d    = {inAlu[31:2], 2'b00};
          be_d      = lane_be;
          wdata_d   = inMemWrite ? lane_wdata : 32'h0;
          ctx_d     = '{off: inAlu[1:0], ldf: inflagLoadWordDividerMEM, store: inMemWrite,
                        alu: inAlu, rd: inMuxRtRd, mtr: inMemtoReg, rw: inRegWrite};
          wb_d.rw   = 1'b0;
        end else begin
          // Pass-through; a misaligned access becomes a flagged bubble.
          err_d = mis;
          wb_d  = '{rdata: 32'h0, alu: inAlu, rd: inMuxRtRd, mtr: inMemtoReg,
                    rw: inRegWrite & ~mis};
        end
      end
      ST_BUSY: begin
        if (memAck) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          wb_d    = '{rdata: ctx_q.store ? 32'h0 : lane_rdata, alu: ctx_q.alu, rd: ctx_q.rd,
                      mtr: ctx_q.mtr, rw: ctx_q.rw};
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          wb_d.rw = 1'b0;
        end else begin
          wb_d.rw = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      wb_q    <= '{rdata: 32'h0, alu: RESET_PC_VAL, rd: 5'h0, mtr: 2'h0, rw: 1'b0};
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      wb_q    <= wb_d;
      ctx_q   <= ctx_d;
    end
  end

  always_comb begin
    if (state_q == ST_IDLE) begin
      outStall = go;
    end else begin
      outStall = ~memAck & ~timeout_hit;
    end
  end

  assign memReq        = req_q;
  assign memWe         = we_q;
  assign memAddr       = addr_q;
  assign memBe         = be_q;
  assign memWdata      = wdata_q;
  assign outAddrErr    = err_q;
  assign outReadData   = wb_q.rdata;
  assign outAluWb      = wb_q.alu;
  assign outMuxRtRdWb  = wb_q.rd;
  assign outMemtoRegWb = wb_q.mtr;
  assign outRegWriteWb = wb_q.rw;

endmodule
